// File: rtl/dig_spi_responder.sv
// SPI responder: oversampled 16-bit R/Wn+addr+data frames into an 8-bit register file, serial read-back on sdout.
// Latency: pin edges act 3 clk later, wr_stb 1 clk after the 16th sample; no backpressure (master paces every transfer).
module dig_spi_responder #(
  parameter int NUM_REGS = 32,
  parameter bit CPOL     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sen_n,
  input  logic       sclk,
  input  logic       sdata,
  output logic       sdout,
  output logic       sdout_oe,
  output logic       wr_stb,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [6:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       frame_err
);

  localparam int         AW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0] NREGS = 8'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  logic [2:0] sen_sync_q, sclk_sync_q;
  logic [1:0] sdat_sync_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] rd_shift_q, rd_shift_d;
  logic       sdout_q, sdout_d;
  logic       oe_q, oe_d;
  logic       wr_stb_q, wr_stb_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       ferr_q, ferr_d;
  logic       ovl_q, ovl_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];

  logic       sen_rise, sen_fall, sclk_rise, sclk_fall;
  logic [7:0] byte_in, rd_val;
  logic       in_ok, addr_ok;

  assign sen_rise  =  sen_sync_q[1]  & ~sen_sync_q[2];
  assign sen_fall  = ~sen_sync_q[1]  &  sen_sync_q[2];
  assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
  assign byte_in   = {sh_q[6:0], sdat_sync_q[1]};
  assign in_ok     = {1'b0, byte_in[6:0]} < NREGS;
  assign addr_ok   = {1'b0, addr_q} < NREGS;
  assign rd_val    = in_ok ? regs_q[byte_in[AW-1:0]] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sen_sync_q  <= 3'b111;
      sclk_sync_q <= {3{CPOL}};
      sdat_sync_q <= 2'b00;
    end else begin
      sen_sync_q  <= {sen_sync_q[1:0], sen_n};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      sdat_sync_q <= {sdat_sync_q[0], sdata};
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    rd_shift_d = rd_shift_q;
    sdout_d    = sdout_q;
    oe_d       = oe_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    ferr_d     = 1'b0;
    ovl_d      = ovl_q;
    regs_d     = regs_q;

    // sen_n edges take priority over any SCLK edge seen in the same cycle.
    if (state_q != IDLE && sen_rise) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      sdout_d = 1'b0;
      ferr_d  = (state_q != DONE) || ovl_q;
    end else if (sen_fall) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      ovl_d   = 1'b0;
      oe_d    = 1'b0;
      sdout_d = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (sclk_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              rw_d    = byte_in[7];
              addr_d  = byte_in[6:0];
              state_d = DATA;
              if (byte_in[7]) begin
                rd_shift_d = rd_val;
                oe_d       = 1'b1;
                sdout_d    = rd_val[7];
              end
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_d = DONE;
              if (!rw_q && addr_ok) begin
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = byte_in;
                if (addr_q == 7'd0 && byte_in[0]) begin
                  for (int i = 0; i < NUM_REGS; i++) regs_d[i] = 8'h00;
                end else begin
                  regs_d[addr_q[AW-1:0]] = byte_in;
                end
              end
            end
          end else if (sclk_fall && rw_q) begin
            // Launch the current MSB then shift, so both CPOL settings present bit 7 on the 9th rising edge.
            sdout_d    = rd_shift_q[7];
            rd_shift_d = {rd_shift_q[6:0], 1'b0};
          end
        end
        DONE: begin
          // Only rising edges count as extra bits; with CPOL=0 the 16th falling edge lands here legitimately.
          if (sclk_rise) ovl_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 8'h00;
      rw_q       <= 1'b0;
      addr_q     <= 7'd0;
      rd_shift_q <= 8'h00;
      sdout_q    <= 1'b0;
      oe_q       <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= 7'd0;
      wr_data_q  <= 8'h00;
      ferr_q     <= 1'b0;
      ovl_q      <= 1'b0;
      regs_q     <= '{default: 8'h00};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      rd_shift_q <= rd_shift_d;
      sdout_q    <= sdout_d;
      oe_q       <= oe_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ferr_q     <= ferr_d;
      ovl_q      <= ovl_d;
      regs_q     <= regs_d;
    end
  end

  assign sdout     = sdout_q;
  assign sdout_oe  = oe_q;
  assign wr_stb    = wr_stb_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_err = ferr_q;
  assign cfg_data  = ({1'b0, cfg_addr} < NREGS) ? regs_q[cfg_addr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_dig_spi_responder.sv
// Bench for dig_spi_responder: CPOL=1 master at clk/10 with a write scoreboard and a register model.
module tb_dig_spi_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sen_n = 1'b1;
  logic       sclk = 1'b1;
  logic       sdata = 1'b0;
  logic [6:0] cfg_addr = 7'd0;
  logic       sdout, sdout_oe, wr_stb, frame_err;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, cfg_data;

  dig_spi_responder #(.NUM_REGS(32), .CPOL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sen_n(sen_n), .sclk(sclk), .sdata(sdata),
    .sdout(sdout), .sdout_oe(sdout_oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         stb_cnt = 0;
  int         ferr_cnt = 0;
  logic [7:0] model [128];
  logic [6:0] exp_wa_q [$];
  logic [7:0] exp_wd_q [$];
  logic [6:0] mon_wa;
  logic [7:0] mon_wd;
  logic [7:0] rd_cap;
  logic [15:0] oe_seen;

  // Every committed write is popped against the next expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_stb) begin
        stb_cnt++;
        checks++;
        if (exp_wa_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr %h data %h, required no write", wr_addr, wr_data);
        end else begin
          mon_wa = exp_wa_q.pop_front();
          mon_wd = exp_wd_q.pop_front();
          if ({wr_addr, wr_data} !== {mon_wa, mon_wd}) begin
            errors++;
            $display("FAIL wr_commit: got addr %h data %h, required addr %h data %h", wr_addr, wr_data, mon_wa, mon_wd);
          end
        end
      end
      if (frame_err) ferr_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_write(input logic [6:0] a, input logic [7:0] d);
    if (a < 7'd32) begin
      exp_wa_q.push_back(a);
      exp_wd_q.push_back(d);
      if (a == 7'd0 && d[0]) begin
        for (int i = 0; i < 128; i++) model[i] = 8'h00;
      end else begin
        model[a] = d;
      end
    end
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, input bit close);
    rd_cap  = 8'h00;
    oe_seen = 16'h0000;
    @(negedge clk);
    sen_n = 1'b0;
    wclk(5);
    for (int i = 0; i < nbits; i++) begin
      sclk  = 1'b0;
      sdata = (i < 16) ? w[15 - i] : 1'b0;
      wclk(5);
      if (i < 16) begin
        oe_seen[i] = sdout_oe;
        if (i >= 8) rd_cap = {rd_cap[6:0], sdout};
      end
      sclk = 1'b1;
      wclk(5);
    end
    if (close) begin
      wclk(5);
      sen_n = 1'b1;
      wclk(8);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    wclk(3);
    checks++;
    if ({sdout, sdout_oe, wr_stb, wr_addr, wr_data, frame_err} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required 0", {sdout, sdout_oe, wr_stb, wr_addr, wr_data, frame_err});
    end
    for (int a = 0; a < 32; a += 10) begin
      cfg_addr = 7'(a);
      #1;
      checks++;
      if (cfg_data !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h, required 00", a, cfg_data);
      end
    end
    rst_n = 1'b1;
    wclk(4);
  endtask

  task automatic test_write;
    int s0 = stb_cnt;
    int f0 = ferr_cnt;
    expect_write(7'h0A, 8'h5C);
    spi_frame(16'h0A5C, 16, 1'b1);
    checks++;
    if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL write_stb_count: got %0d, required 1", stb_cnt - s0); end
    checks++;
    if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL write_ferr: got %0d, required 0", ferr_cnt - f0); end
    cfg_addr = 7'h0A;
    #1;
    checks++;
    if (cfg_data !== model[7'h0A]) begin errors++; $display("FAIL write_cfg: got %h, required %h", cfg_data, model[7'h0A]); end
    checks++;
    if ({wr_addr, wr_data} !== {7'h0A, 8'h5C}) begin
      errors++;
      $display("FAIL write_hold: got %h/%h, required 0a/5c", wr_addr, wr_data);
    end
  endtask

  task automatic test_read;
    int s0 = stb_cnt;
    spi_frame(16'h8A00, 16, 1'b1);
    checks++;
    if (rd_cap !== model[7'h0A]) begin errors++; $display("FAIL read_data: got %h, required %h", rd_cap, model[7'h0A]); end
    checks++;
    if (oe_seen !== 16'hFF00) begin errors++; $display("FAIL read_oe_window: got %h, required ff00", oe_seen); end
    checks++;
    if ({sdout_oe, sdout} !== 2'b00) begin errors++; $display("FAIL read_release: got %b, required 00", {sdout_oe, sdout}); end
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL read_no_stb: got %0d, required 0", stb_cnt - s0); end
  endtask

  task automatic test_out_of_range;
    int s0;
    spi_frame(16'hFF00, 16, 1'b1);
    checks++;
    if (rd_cap !== 8'h00) begin errors++; $display("FAIL oor_read: got %h, required 00", rd_cap); end
    s0 = stb_cnt;
    expect_write(7'h7F, 8'h11);
    spi_frame(16'h7F11, 16, 1'b1);
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL oor_no_stb: got %0d, required 0", stb_cnt - s0); end
    for (int a = 0; a < 32; a++) begin
      cfg_addr = 7'(a);
      #1;
      checks++;
      if (cfg_data !== model[a]) begin errors++; $display("FAIL oor_reg%0d: got %h, required %h", a, cfg_data, model[a]); end
    end
    cfg_addr = 7'h7F;
    #1;
    checks++;
    if (cfg_data !== 8'h00) begin errors++; $display("FAIL oor_cfg: got %h, required 00", cfg_data); end
  endtask

  task automatic test_abort;
    int s0 = stb_cnt;
    int f0 = ferr_cnt;
    spi_frame(16'h0333, 11, 1'b1);
    checks++;
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL abort_ferr: got %0d cycles, required 1", ferr_cnt - f0); end
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL abort_no_stb: got %0d, required 0", stb_cnt - s0); end
    checks++;
    if (sdout_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b, required 0", sdout_oe); end
    cfg_addr = 7'h03;
    #1;
    checks++;
    if (cfg_data !== model[3]) begin errors++; $display("FAIL abort_reg3: got %h, required %h", cfg_data, model[3]); end
    expect_write(7'h03, 8'h33);
    spi_frame(16'h0333, 16, 1'b1);
    #1;
    checks++;
    if (cfg_data !== 8'h33) begin errors++; $display("FAIL abort_retry: got %h, required 33", cfg_data); end
  endtask

  task automatic test_soft_reset;
    for (int a = 1; a <= 3; a++) begin
      expect_write(7'(a), 8'hFF);
      spi_frame({1'b0, 7'(a), 8'hFF}, 16, 1'b1);
    end
    cfg_addr = 7'h02;
    #1;
    checks++;
    if (cfg_data !== 8'hFF) begin errors++; $display("FAIL soft_pre: got %h, required ff", cfg_data); end
    expect_write(7'h00, 8'h01);
    spi_frame(16'h0001, 16, 1'b1);
    for (int a = 0; a <= 3; a++) begin
      cfg_addr = 7'(a);
      #1;
      checks++;
      if (cfg_data !== model[a]) begin errors++; $display("FAIL soft_reg%0d: got %h, required %h", a, cfg_data, model[a]); end
    end
    cfg_addr = 7'h0A;
    #1;
    checks++;
    if (cfg_data !== 8'h00) begin errors++; $display("FAIL soft_reg10: got %h, required 00", cfg_data); end
  endtask

  task automatic test_overlength;
    int s0 = stb_cnt;
    int f0 = ferr_cnt;
    expect_write(7'h02, 8'h77);
    spi_frame(16'h0277, 18, 1'b1);
    checks++;
    if (stb_cnt - s0 !== 1) begin errors++; $display("FAIL ovl_stb: got %0d, required 1", stb_cnt - s0); end
    checks++;
    if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL ovl_ferr: got %0d cycles, required 1", ferr_cnt - f0); end
    cfg_addr = 7'h02;
    #1;
    checks++;
    if (cfg_data !== model[2]) begin errors++; $display("FAIL ovl_reg2: got %h, required %h", cfg_data, model[2]); end
  endtask

  task automatic test_back_to_back;
    expect_write(7'h05, 8'hA3);
    spi_frame(16'h05A3, 16, 1'b1);
    expect_write(7'h06, 8'h3C);
    spi_frame(16'h063C, 16, 1'b1);
    spi_frame(16'h8500, 16, 1'b1);
    checks++;
    if (rd_cap !== model[5]) begin errors++; $display("FAIL b2b_read5: got %h, required %h", rd_cap, model[5]); end
    spi_frame(16'h8600, 16, 1'b1);
    checks++;
    if (rd_cap !== model[6]) begin errors++; $display("FAIL b2b_read6: got %h, required %h", rd_cap, model[6]); end
  endtask

  task automatic test_reset_midframe;
    int s0 = stb_cnt;
    spi_frame(16'h0455, 12, 1'b0);
    rst_n = 1'b0;
    wclk(2);
    checks++;
    if ({sdout, sdout_oe, wr_stb, wr_addr, wr_data, frame_err} !== 19'd0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h, required 0", {sdout, sdout_oe, wr_stb, wr_addr, wr_data, frame_err});
    end
    sclk  = 1'b1;
    sen_n = 1'b1;
    wclk(3);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    wclk(10);
    checks++;
    if (stb_cnt - s0 !== 0) begin errors++; $display("FAIL midrst_no_stb: got %0d, required 0", stb_cnt - s0); end
    cfg_addr = 7'h04;
    #1;
    checks++;
    if (cfg_data !== model[4]) begin errors++; $display("FAIL midrst_reg4: got %h, required %h", cfg_data, model[4]); end
    cfg_addr = 7'h05;
    #1;
    checks++;
    if (cfg_data !== model[5]) begin errors++; $display("FAIL midrst_reg5: got %h, required %h", cfg_data, model[5]); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) model[i] = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_abort();
    test_soft_reset();
    test_overlength();
    test_back_to_back();
    test_reset_midframe();
    checks++;
    if (exp_wa_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding, required 0", exp_wa_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
